// File: rtl/pixel_frame_receiver_pkg.sv
// Constants and receive-state encoding shared by the rasterizer and the
// pixel frame receiver.
package gp_pkg;

    localparam int GRID         = 8;
    localparam int PIXEL_W      = 4;
    localparam int FRAME_PIXELS = GRID * GRID;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_e;

    function automatic logic [GRID-1:0] row_onehot(input logic [2:0] row);
        return 8'b0000_0001 << row;
    endfunction

endpackage

// File: rtl/led_row_scanner.sv
// Free-running row multiplexer for the 8x8 LED matrix: 4-bit PWM per pixel,
// each row held for PWM_REPEAT full PWM periods.
module led_row_scanner
    import gp_pkg::*;
#(
    parameter int PWM_REPEAT = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [GRID*PIXEL_W-1:0]   row_pix_i,
    output logic [2:0]                row_idx_o,
    output logic [GRID-1:0]           row_sel_o,
    output logic [GRID-1:0]           col_data_o
);

    logic [3:0]      pwm_cnt_q, pwm_cnt_d;
    logic [3:0]      rep_cnt_q, rep_cnt_d;
    logic [2:0]      row_idx_q, row_idx_d;
    logic [GRID-1:0] row_sel_q, row_sel_d;
    logic [GRID-1:0] col_data_q, col_data_d;

    always_comb begin
        pwm_cnt_d  = pwm_cnt_q + 4'd1;
        rep_cnt_d  = rep_cnt_q;
        row_idx_d  = row_idx_q;
        row_sel_d  = row_onehot(row_idx_q);
        col_data_d = '0;
        if (pwm_cnt_q == 4'hF) begin
            if (rep_cnt_q == 4'(PWM_REPEAT - 1)) begin
                rep_cnt_d = 4'd0;
                row_idx_d = row_idx_q + 3'd1;
            end else begin
                rep_cnt_d = rep_cnt_q + 4'd1;
            end
        end
        // Intensity 15 stays dark only on pwm_cnt 15, intensity 0 never lights.
        for (int c = 0; c < GRID; c++) begin
            col_data_d[c] = row_pix_i[c*PIXEL_W +: PIXEL_W] > pwm_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q  <= '0;
            rep_cnt_q  <= '0;
            row_idx_q  <= '0;
            row_sel_q  <= '0;
            col_data_q <= '0;
        end else begin
            pwm_cnt_q  <= pwm_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            row_idx_q  <= row_idx_d;
            row_sel_q  <= row_sel_d;
            col_data_q <= col_data_d;
        end
    end

    assign row_idx_o  = row_idx_q;
    assign row_sel_o  = row_sel_q;
    assign col_data_o = col_data_q;

endmodule

// File: rtl/pixel_frame_receiver.sv
// Consumer end of the rasterizer pixel stream: rebuilds 64-pixel frames into a
// double-buffered frame store and drives the scanned 8x8 LED matrix.
module pixel_frame_receiver
    import gp_pkg::*;
#(
    parameter int PWM_REPEAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic [PIXEL_W-1:0] pixel_data,
    output logic [GRID-1:0]    row_sel,
    output logic [GRID-1:0]    col_data,
    output logic               frame_done,
    output logic               frame_abort
);

    logic [PIXEL_W-1:0]      bank_q [2][FRAME_PIXELS];
    rx_state_e               state_q;
    logic [5:0]              wr_cnt_q;
    logic                    bank_sel_q;
    logic                    done_q;
    logic                    abort_q;
    logic                    wr_en;
    logic [2:0]              row_idx;
    logic [GRID*PIXEL_W-1:0] row_pix;

    // bank_sel_q names the display bank; the other bank takes the incoming frame.
    assign wr_en = (state_q == RECV) && !frame_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_cnt_q   <= '0;
            bank_sel_q <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            if (frame_start) begin
                abort_q  <= (state_q == RECV);
                state_q  <= RECV;
                wr_cnt_q <= '0;
            end else if (state_q == RECV) begin
                wr_cnt_q <= wr_cnt_q + 6'd1;
                if (wr_cnt_q == 6'(FRAME_PIXELS - 1)) begin
                    bank_sel_q <= ~bank_sel_q;
                    done_q     <= 1'b1;
                    state_q    <= IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int p = 0; p < FRAME_PIXELS; p++) begin
                    bank_q[b][p] <= '0;
                end
            end
        end else if (wr_en) begin
            bank_q[~bank_sel_q][wr_cnt_q] <= pixel_data;
        end
    end

    always_comb begin
        row_pix = '0;
        for (int c = 0; c < GRID; c++) begin
            row_pix[c*PIXEL_W +: PIXEL_W] = bank_q[bank_sel_q][{row_idx, 3'(c)}];
        end
    end

    led_row_scanner #(
        .PWM_REPEAT (PWM_REPEAT)
    ) u_scanner (
        .clk        (clk),
        .rst_n      (rst_n),
        .row_pix_i  (row_pix),
        .row_idx_o  (row_idx),
        .row_sel_o  (row_sel),
        .col_data_o (col_data)
    );

    assign frame_done  = done_q;
    assign frame_abort = abort_q;

endmodule

// File: tb/tb_pixel_frame_receiver.sv
// Randomized bench for pixel_frame_receiver against a frame-level reference model.
module tb_pixel_frame_receiver;

    localparam int R = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic [3:0] pixel_data = 4'h0;
    logic [7:0] row_sel;
    logic [7:0] col_data;
    logic       frame_done;
    logic       frame_abort;

    pixel_frame_receiver #(.PWM_REPEAT(R)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .pixel_data  (pixel_data),
        .row_sel     (row_sel),
        .col_data    (col_data),
        .frame_done  (frame_done),
        .frame_abort (frame_abort)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the frame currently shown, the frame being collected,
    // and the number of edges since reset release.
    logic [3:0] disp [64];
    logic [3:0] wbuf [64];
    logic [3:0] fb   [64];
    bit         rx_active;
    int         rx_cnt;
    int         ncyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 64; i++) begin
            disp[i] = 4'h0;
            wbuf[i] = 4'h0;
        end
        rx_active = 1'b0;
        rx_cnt    = 0;
        ncyc      = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_row_sel"}, 32'(row_sel), 32'h0);
        chk({tag, "_col_data"}, 32'(col_data), 32'h0);
        chk({tag, "_done"}, 32'(frame_done), 32'h0);
        chk({tag, "_abort"}, 32'(frame_abort), 32'h0);
    endtask

    task automatic step(input bit fs, input logic [3:0] pix);
        logic [7:0] er;
        logic [7:0] ec;
        bit         ed;
        bit         ea;
        int         row;
        int         pwm;
        frame_start = fs;
        pixel_data  = pix;
        row = (ncyc / (16 * R)) % 8;
        pwm = ncyc % 16;
        er  = 8'(1 << row);
        for (int c = 0; c < 8; c++) ec[c] = (int'(disp[row*8 + c]) > pwm);
        ed = 1'b0;
        ea = 1'b0;
        if (fs) begin
            ea        = rx_active;
            rx_active = 1'b1;
            rx_cnt    = 0;
        end else if (rx_active) begin
            wbuf[rx_cnt] = pix;
            if (rx_cnt == 63) begin
                for (int i = 0; i < 64; i++) disp[i] = wbuf[i];
                ed        = 1'b1;
                rx_active = 1'b0;
            end else begin
                rx_cnt++;
            end
        end
        @(posedge clk);
        #1;
        chk("row_sel", 32'(row_sel), 32'(er));
        chk("col_data", 32'(col_data), 32'(ec));
        chk("frame_done", 32'(frame_done), 32'(ed));
        chk("frame_abort", 32'(frame_abort), 32'(ea));
        ncyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'($urandom));
    endtask

    task automatic send(input int npix);
        step(1'b1, 4'($urandom));
        for (int k = 0; k < npix; k++) step(1'b0, fb[k]);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) fb[i] = 4'($urandom);
    endtask

    initial begin
        reset_model();
        repeat (3) begin
            @(posedge clk);
            #1;
            chk_zero("reset");
        end
        rst_n = 1'b1;

        // Empty display: rows step through with dark columns
        idle(300);

        // Single lit pixel at x=3, y=2
        for (int i = 0; i < 64; i++) fb[i] = 4'h0;
        fb[19] = 4'hF;
        send(64);
        idle(300);

        // Row 0 ramp 0,1,8,15
        fill_random();
        fb[0] = 4'h0;
        fb[1] = 4'h1;
        fb[2] = 4'h8;
        fb[3] = 4'hF;
        send(64);
        idle(280);

        // Abort after pixel 20, then a complete frame
        fill_random();
        send(21);
        fill_random();
        send(64);
        idle(60);

        // Back-to-back frames A then B
        fill_random();
        send(64);
        fill_random();
        send(64);
        idle(270);

        // Random frames, random aborts, random gaps (zero gap = back-to-back)
        for (int f = 0; f < 8; f++) begin
            if ($urandom_range(0, 2) == 0) begin
                fill_random();
                send($urandom_range(0, 63));
            end
            fill_random();
            send(64);
            idle($urandom_range(0, 20));
        end
        idle(260);

        // Asynchronous reset in the middle of a frame
        fill_random();
        send(40);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        reset_model();
        repeat (2) begin
            @(posedge clk);
            #1;
            chk_zero("reset_hold");
        end
        rst_n = 1'b1;

        // Stray pixels without frame_start must not complete a frame
        idle(80);
        fill_random();
        send(64);
        idle(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pixel_frame_receiver.md
# pixel_frame_receiver

- Receives the serial 64-pixel stream driven by the graphics processor (`frame_start` strobe, then `pixel_data` in raster order) and rebuilds it into a double-buffered 8x8 frame store.
- Continuously scans the completed frame onto a row-multiplexed 8x8 LED matrix, with 4-bit PWM intensity per pixel.
- Sits between the rasterizer output and the top-level LED pins; it is the consumer end of the rasterizer's pixel-stream interface.

## Interface
Parameters:
- `PWM_REPEAT`, default 1: number of full 16-cycle PWM periods each row is held before advancing (range 1..15).

Ports:
- `clk`  in  1  single system clock; everything is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `frame_start`  in  1  one-cycle strobe from the rasterizer marking the start of a frame.
- `pixel_data`  in  4  pixel intensity, 0 = off, 15 = brightest.
- `row_sel`  out  8  one-hot active-high row drive; bit r = row r.
- `col_data`  out  8  active-high column drive for the current row; bit c = column c.
- `frame_done`  out  1  one-cycle pulse: a complete frame was captured and banks were swapped.
- `frame_abort`  out  1  one-cycle pulse: a partial frame was discarded.

## Operation
- Stream protocol:
  - Let S be the edge at which `frame_start` is sampled high.
  - Pixel k (k = 0..63) is sampled at edge S+1+k.
  - Pixel k maps to row k[5:3], column k[2:0].
  - `pixel_data` is ignored on any edge where `frame_start` is high, and whenever the receiver is in IDLE.
- Receive FSM has two states, IDLE and RECV, with a 6-bit pixel counter `wr_cnt`.
  - IDLE: on `frame_start` go to RECV with `wr_cnt` = 0.
  - RECV, no `frame_start`: write `pixel_data` into the write bank at `wr_cnt`, then increment `wr_cnt`.
  - RECV, `wr_cnt` == 63, no `frame_start`: write the pixel, toggle the bank select, pulse `frame_done`, return to IDLE.
  - RECV, `frame_start` high: pulse `frame_abort`, set `wr_cnt` to 0, stay in RECV.
    - The partial data stays in the write bank and is overwritten by the new frame.
    - No swap occurs.
    - `frame_start` has priority on every edge, including the edge that would have sampled pixel 63.
- Storage: two banks of 64 x 4 bits, one write bank and one display bank.
  - The bank swap is immediate. A row scan in progress may show the new bank from that edge onward; this tearing is accepted.
- Scanner, independent of the receive FSM and free-running after reset:
  - `pwm_cnt` is 4 bits and wraps 15 -> 0.
  - `rep_cnt` counts PWM periods up to `PWM_REPEAT`.
  - `row_idx` is 3 bits and wraps 7 -> 0.
  - The row advances on the edge where `pwm_cnt` == 15 and `rep_cnt` == `PWM_REPEAT`-1.
  - Column rule: `col_data`[c] = (display_bank[row_idx][c] > `pwm_cnt`). Intensity 0 is never lit; intensity 15 is lit 15 of 16 cycles.
- All comparisons are unsigned 4-bit. There is no gamma correction.

## Timing
- Reset values:
  - Outputs: `row_sel` = 8'h00, `col_data` = 8'h00, `frame_done` = 0, `frame_abort` = 0.
  - Internal: both banks all-zero, bank select = 0, FSM IDLE, `wr_cnt` = 0, `pwm_cnt` = 0, `rep_cnt` = 0, `row_idx` = 0.
- `row_sel` and `col_data` are registered. The first edge after reset release drives `row_sel` = 8'h01 with columns for `pwm_cnt` = 0.
- Output latency is 1 cycle: the outputs visible after edge E reflect `row_idx`, `pwm_cnt` and the display bank as they stood before E.
- `frame_done` is high for exactly the cycle after the edge that samples pixel 63 (edge S+64).
- The new bank is visible on `col_data` one cycle after `frame_done` rises.
- `frame_abort` is high for exactly the cycle after the aborting `frame_start` edge.
- Back-to-back frames are supported: `frame_start` sampled at S+65 starts the next frame with no lost pixels.
- Asserting reset mid-frame or mid-scan returns everything to its reset values immediately. No partial frame survives.

## Structure
- Shared package `gp_pkg` holds:
  - `GRID` = 8 and `PIXEL_W` = 4;
  - the receive-state enum (IDLE, RECV);
  - `FRAME_PIXELS` = 64.
  The rasterizer uses the same constants.
- One sub-module, `led_row_scanner`, contains `pwm_cnt`, `rep_cnt`, `row_idx`, the one-hot row decode and the column compare.
  - Its input is the 32-bit row slice of the display bank.
- Bank storage, bank select and the receive FSM stay in the top module.

## Test plan
- Reset release, no stream, `PWM_REPEAT` = 1: `row_sel` steps 01, 02, … 80, 01 every 16 cycles; `col_data` stays 8'h00 throughout.
- One frame with pixel (x=3, y=2) = 15 and all others 0:
  - `frame_done` is high at cycle S+65;
  - while `row_sel` = 8'h04, `col_data` = 8'h08 for 15 of 16 cycles and 8'h00 when `pwm_cnt` = 15.
- Row 0 intensities 0,1,8,15 in columns 0..3: over one PWM period the column on-counts are 0, 1, 8, 15.
- `frame_start` again after pixel 20 of a frame:
  - `frame_abort` pulses once;
  - the display still shows the previous frame;
  - the next 64 pixels complete with a single `frame_done`.
- Two back-to-back frames, A then B, with `frame_start` at S+65: two `frame_done` pulses 65 cycles apart, and B is displayed.
- `rst_n` low at pixel 40: all outputs and banks are zero; after release, a full frame is required before any `frame_done`.
